// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader.
//   loader_state_t : framing FSM states of the top level
//   rx_state_t     : bit-level receiver states
//   HDR_BYTES      : bytes in the little-endian word-count header
//   WORD_BYTES     : bytes per little-endian payload word
package uart_loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    CSUM,
    HOLD,
    DONE
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/uart_loader_rx.sv
// uart_rx_byte: 8N1 UART byte receiver.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial line, idle high
//   byte_valid out  one-cycle strobe, byte_data holds a good byte
//   byte_data  out  last received byte (LSB received first)
//   frame_err  out  one-cycle strobe, stop bit sampled low
// Parameter BIT_DIV: clk cycles per bit (must be >= 2).
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int BIT_DIV = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(BIT_DIV + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BIT_DIV - 1);

  rx_state_t     state_q, state_d;
  logic [1:0]    sync_q;
  logic          rx_sync;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_d, err_d;

  assign rx_sync   = sync_q[1];
  assign byte_data = shift_q;

  // Synchroniser resets to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= 2'b11;
      prev_q     <= 1'b1;
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      prev_q     <= rx_sync;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_valid <= valid_d;
      frame_err  <= err_d;
    end
  end

  // A start edge is rechecked half a bit later; a line already back high was a glitch.
  // After that every sample lands at mid-bit, one full bit period apart.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_sync) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? RX_IDLE : RX_BITS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_BITS: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync) begin
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_loader.sv
// uart_loader: serial program loader. Receives a framed image (4-byte LE word count N,
// then N LE words) and presents each word as uart_addr/uart_data for the CPU memory port.
// uart_done rises DONE_HOLD cycles after the final write and is then terminal until rst.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high board reset
//   rx           in   UART serial in, idle high, asynchronous
//   uart_addr    out  32-bit byte address of the last completed word
//   uart_data    out  32-bit data of the last completed word
//   uart_done    out  image complete, CPU may run
//   load_err     out  sticky framing / count / checksum error
//   words_loaded out  words written so far
// Optional feature: define UART_LOADER_CHECKSUM_EN to expect a trailing XOR byte
// over all payload bytes after the last word.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int          CLK_HZ    = 25_000_000,
  parameter int          BAUD      = 115_200,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_WORDS = 16384,
  parameter int          DONE_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] uart_addr,
  output logic [31:0] uart_data,
  output logic        uart_done,
  output logic        load_err,
  output logic [15:0] words_loaded
);

  localparam int BIT_DIV = CLK_HZ / BAUD;

  loader_state_t state_q, state_d;
  logic          byte_valid, frame_err;
  logic [7:0]    byte_data;
  logic [23:0]   asm_q;
  logic [1:0]    byte_cnt_q;
  logic [31:0]   count_q;
  logic [15:0]   word_idx_q;
  logic [7:0]    csum_q;
  logic [15:0]   hold_q;
  logic [31:0]   full_word;
  logic          last_word;
  logic          take_byte, hdr_ok, word_done, set_err;

  uart_rx_byte #(
    .BIT_DIV(BIT_DIV)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  // Earlier bytes sit in asm_q; the byte arriving now completes the little-endian word.
  assign full_word = {byte_data, asm_q};
  assign last_word = ({16'b0, word_idx_q} + 32'd1) == count_q;
  assign uart_done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // A framing error anywhere short of DONE restarts header hunting.
  always_comb begin
    state_d   = state_q;
    take_byte = 1'b0;
    hdr_ok    = 1'b0;
    word_done = 1'b0;
    set_err   = 1'b0;
    if (state_q != DONE && frame_err) begin
      set_err = 1'b1;
      state_d = HDR;
    end else begin
      case (state_q)
        HDR: begin
          if (byte_valid) begin
            take_byte = 1'b1;
            if (byte_cnt_q == 2'(HDR_BYTES - 1)) begin
              if (full_word == 32'd0) begin
                state_d = HOLD;
              end else if (full_word > 32'(MAX_WORDS)) begin
                set_err = 1'b1;
              end else begin
                hdr_ok  = 1'b1;
                state_d = DATA;
              end
            end
          end
        end
        DATA: begin
          if (byte_valid) begin
            take_byte = 1'b1;
            if (byte_cnt_q == 2'(WORD_BYTES - 1)) begin
              word_done = 1'b1;
              if (last_word) begin
`ifdef UART_LOADER_CHECKSUM_EN
                state_d = CSUM;
`else
                state_d = HOLD;
`endif
              end
            end
          end
        end
        CSUM: begin
          if (byte_valid) begin
            if (byte_data == csum_q) begin
              state_d = HOLD;
            end else begin
              set_err = 1'b1;
              state_d = HDR;
            end
          end
        end
        HOLD: begin
          if (hold_q == 16'(DONE_HOLD - 1)) begin
            state_d = DONE;
          end
        end
        DONE: state_d = DONE;
        default: state_d = HDR;
      endcase
    end
  end

  // Outputs move only when a whole word lands, so the memory port sees stable values.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q        <= '0;
      byte_cnt_q   <= '0;
      count_q      <= '0;
      word_idx_q   <= '0;
      csum_q       <= '0;
      hold_q       <= '0;
      uart_addr    <= BASE_ADDR;
      uart_data    <= '0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      if (set_err) begin
        load_err   <= 1'b1;
        byte_cnt_q <= '0;
      end else if (take_byte) begin
        asm_q      <= {byte_data, asm_q[23:8]};
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      if (hdr_ok) begin
        count_q    <= full_word;
        word_idx_q <= '0;
        csum_q     <= '0;
      end
      if (take_byte && state_q == DATA) begin
        csum_q <= csum_q ^ byte_data;
      end
      if (word_done) begin
        uart_data    <= full_word;
        uart_addr    <= BASE_ADDR + {14'b0, word_idx_q, 2'b00};
        words_loaded <= word_idx_q + 16'd1;
        word_idx_q   <= word_idx_q + 16'd1;
      end
      hold_q <= (state_q == HOLD) ? hold_q + 16'd1 : 16'd0;
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader. Frames are built from word lists by a
// reference model that also queues the expected memory writes; a monitor pops
// and compares on every observed write and checks the DONE_HOLD latency.
module tb_uart_loader;

  localparam int          CLK_HZ    = 1_600_000;
  localparam int          BAUD      = 100_000;
  localparam int          BIT_DIV   = CLK_HZ / BAUD;
  localparam int          MAX_WORDS = 8;
  localparam int          DONE_HOLD = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [31:0] uart_addr, uart_data;
  logic        uart_done, load_err;
  logic [15:0] words_loaded;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] wl;
  } upd_t;

  upd_t        exp_q[$];
  logic [7:0]  tx_q[$];
  int          checks   = 0;
  int          errors   = 0;
  int          cycle    = 0;
  int          last_upd = -1;

  uart_loader #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .BASE_ADDR(BASE_ADDR),
    .MAX_WORDS(MAX_WORDS),
    .DONE_HOLD(DONE_HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .uart_addr   (uart_addr),
    .uart_data   (uart_data),
    .uart_done   (uart_done),
    .load_err    (load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: any change of the write port is one memory write to be matched.
  initial begin : monitor
    logic [31:0] pa, pd;
    logic [15:0] pw;
    logic        pdone;
    upd_t        e;
    pa = BASE_ADDR; pd = '0; pw = '0; pdone = 1'b0;
    forever begin
      @(negedge clk);
      cycle++;
      if (rst) begin
        last_upd = -1;
      end else begin
        if (uart_addr !== pa || uart_data !== pd || words_loaded !== pw) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write: addr 0x%08h data 0x%08h words %0d, none expected",
                     uart_addr, uart_data, words_loaded);
          end else begin
            e = exp_q.pop_front();
            checkOutput("write_addr", uart_addr, e.addr);
            checkOutput("write_data", uart_data, e.data);
            checkOutput("write_count", 32'(words_loaded), 32'(e.wl));
          end
          last_upd = cycle;
        end
        if (uart_done && !pdone && last_upd >= 0) begin
          checkOutput("done_latency", 32'(cycle - last_upd), 32'(DONE_HOLD));
        end
      end
      pa = uart_addr; pd = uart_data; pw = words_loaded; pdone = uart_done;
    end
  end

  initial begin : watchdog
    #(900_000);
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic pushWord(input logic [31:0] w);
    for (int b = 0; b < 4; b++) tx_q.push_back(w[8*b +: 8]);
  endtask

  // Reference model: frame = LE count, LE words, optional XOR of payload bytes.
  task automatic buildFrame(input logic [31:0] words[$], input bit expect_writes, input bit bad_csum);
    logic [7:0] x;
    x = 8'h00;
    tx_q.delete();
    pushWord(32'(words.size()));
    foreach (words[i]) begin
      pushWord(words[i]);
      x = x ^ words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
      if (expect_writes)
        exp_q.push_back('{addr: BASE_ADDR + 32'(4 * i), data: words[i], wl: 16'(i + 1)});
    end
    if (bad_csum) x = ~x;
`ifdef UART_LOADER_CHECKSUM_EN
    tx_q.push_back(x);
`endif
  endtask

  task automatic sendByte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (BIT_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_DIV) @(negedge clk);
    end
    rx = !bad_stop;
    repeat (BIT_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_DIV) @(negedge clk);
  endtask

  // Sends the first n_bytes of tx_q (all if negative); byte bad_idx gets a low stop bit and ends the burst.
  task automatic applyStimulus(input int n_bytes, input int bad_idx);
    int lim;
    lim = (n_bytes < 0) ? tx_q.size() : n_bytes;
    for (int i = 0; i < lim; i++) begin
      sendByte(tx_q[i], i == bad_idx);
      if (i == bad_idx) break;
    end
  endtask

  task automatic waitDone(input bit want);
    int n;
    n = 0;
    if (want) begin
      while (!uart_done && n < 400) begin
        @(negedge clk);
        n++;
      end
    end else begin
      repeat (60) @(negedge clk);
    end
    checkOutput("uart_done", 32'(uart_done), 32'(want));
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_done", 32'(uart_done), 32'd0);
    checkOutput("rst_addr", uart_addr, BASE_ADDR);
    checkOutput("rst_data", uart_data, 32'd0);
    checkOutput("rst_err", 32'(load_err), 32'd0);
    checkOutput("rst_words", 32'(words_loaded), 32'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stimulus
    logic [31:0] w[$];
    logic [31:0] none[$];
    int          n;

    $display("[TB] start, BIT_DIV=%0d", BIT_DIV);

    // Reset values, then the two-word reference frame.
    doReset();
    w = '{32'h0000_0093, 32'h0010_0113};
    buildFrame(w, 1'b1, 1'b0);
    applyStimulus(-1, -1);
    waitDone(1'b1);
    checkOutput("t2_err", 32'(load_err), 32'd0);
    checkOutput("t2_words", 32'(words_loaded), 32'd2);

    // Zero-length image goes straight to done with no write.
    doReset();
    none.delete();
    buildFrame(none, 1'b0, 1'b0);
    applyStimulus(-1, -1);
    waitDone(1'b1);
    checkOutput("t3_addr", uart_addr, BASE_ADDR);
    checkOutput("t3_words", 32'(words_loaded), 32'd0);

    // Bad stop bit on the second data byte, then a full good resend.
    doReset();
    buildFrame(w, 1'b0, 1'b0);
    applyStimulus(-1, 5);
    repeat (2 * BIT_DIV) @(negedge clk);
    checkOutput("t4_err", 32'(load_err), 32'd1);
    checkOutput("t4_done", 32'(uart_done), 32'd0);
    checkOutput("t4_words", 32'(words_loaded), 32'd0);
    buildFrame(w, 1'b1, 1'b0);
    applyStimulus(-1, -1);
    waitDone(1'b1);
    checkOutput("t4_err_sticky", 32'(load_err), 32'd1);

    // Short low glitch must not be taken as a start bit.
    doReset();
    rx = 1'b0;
    repeat (BIT_DIV / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_DIV) @(negedge clk);
    checkOutput("t5_err", 32'(load_err), 32'd0);
    w = '{$urandom()};
    buildFrame(w, 1'b1, 1'b0);
    applyStimulus(-1, -1);
    waitDone(1'b1);
    checkOutput("t5_err_after", 32'(load_err), 32'd0);

    // Reset after one of three words, then a fresh one-word frame.
    doReset();
    w = '{$urandom(), $urandom(), $urandom()};
    buildFrame(w, 1'b1, 1'b0);
    applyStimulus(8, -1);
    checkOutput("t6_one_written", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    doReset();
    w = '{$urandom()};
    buildFrame(w, 1'b1, 1'b0);
    applyStimulus(-1, -1);
    waitDone(1'b1);

    // Count one above the limit is rejected; exactly the limit is accepted.
    doReset();
    tx_q.delete();
    pushWord(32'(MAX_WORDS + 1));
    applyStimulus(-1, -1);
    repeat (BIT_DIV) @(negedge clk);
    checkOutput("max_err", 32'(load_err), 32'd1);
    w.delete();
    for (int i = 0; i < MAX_WORDS; i++) w.push_back($urandom());
    buildFrame(w, 1'b1, 1'b0);
    applyStimulus(-1, -1);
    waitDone(1'b1);
    checkOutput("max_words", 32'(words_loaded), 32'(MAX_WORDS));

`ifdef UART_LOADER_CHECKSUM_EN
    // Wrong checksum byte: words land but the image is refused.
    doReset();
    w = '{$urandom(), $urandom()};
    buildFrame(w, 1'b1, 1'b1);
    applyStimulus(-1, -1);
    waitDone(1'b0);
    checkOutput("csum_err", 32'(load_err), 32'd1);
`endif

    // Randomized frames.
    for (int k = 0; k < 5; k++) begin
      doReset();
      n = $urandom_range(1, 4);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom());
      buildFrame(w, 1'b1, 1'b0);
      applyStimulus(-1, -1);
      waitDone(1'b1);
      checkOutput("rand_words", 32'(words_loaded), 32'(n));
      checkOutput("rand_addr", uart_addr, BASE_ADDR + 32'(4 * (n - 1)));
      checkOutput("rand_data", uart_data, w[n-1]);
      checkOutput("rand_err", 32'(load_err), 32'd0);
    end

    // Done is terminal: further traffic is ignored.
    sendByte(8'h00, 1'b1);
    repeat (BIT_DIV) @(negedge clk);
    checkOutput("done_terminal", 32'(uart_done), 32'd1);
    checkOutput("done_no_err", 32'(load_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
